// File: rtl/sig_dump_uart.sv
// sig_dump_uart: reads the word range [begin, end) over a request/grant port
// and streams each word as eight lowercase hex characters plus a line feed on
// an 8N1 UART transmit pin.
`timescale 1ns/1ps

module sig_dump_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] begin_addr_i,
  input  logic [31:0] end_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [31:0] mem_data_i,
  output logic        tx_pin_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    NEXT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cur_addr;
  logic [31:0] end_addr;
  logic [31:0] word_reg;
  logic [3:0]  char_idx;
  logic [3:0]  bit_cnt;
  logic [15:0] baud_cnt;
  logic [9:0]  shifter;

  logic [31:0] begin_aligned;
  logic [31:0] end_aligned;
  logic [32:0] cur_inc;
  logic [3:0]  nibble;
  logic [7:0]  char_code;
  logic        bit_end;
  logic        frame_end;

  // Address alignment, next-word address with carry, and the ASCII character for the current index
  always_comb begin
    begin_aligned = {begin_addr_i[31:2], 2'b00};
    end_aligned   = {end_addr_i[31:2], 2'b00};
    cur_inc       = {1'b0, cur_addr} + 33'd4;
    nibble        = word_reg[31:28];
    bit_end       = (baud_cnt == BAUD_LAST);
    frame_end     = bit_end && (bit_cnt == 4'd9);
    char_code     = 8'h0A;
    if (char_idx != 4'd8) begin
      if (nibble < 4'd10) begin
        char_code = 8'h30 + {4'h0, nibble};
      end else begin
        char_code = 8'h57 + {4'h0, nibble};
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    state_nxt  = state;
    mem_req_o  = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    mem_addr_o = cur_addr;
    tx_pin_o   = shifter[0];
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          state_nxt = (begin_aligned >= end_aligned) ? DONE : FETCH;
        end
      end
      FETCH: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (frame_end) begin
          state_nxt = (char_idx == 4'd8) ? NEXT : LOAD;
        end
      end
      NEXT: begin
        state_nxt = (cur_inc[32] || (cur_inc[31:0] >= end_addr)) ? DONE : FETCH;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: address capture, word latch, frame build and bit-serial shifting
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_addr <= 32'h0;
      end_addr <= 32'h0;
      word_reg <= 32'h0;
      char_idx <= 4'd0;
      bit_cnt  <= 4'd0;
      baud_cnt <= 16'd0;
      shifter  <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            cur_addr <= begin_aligned;
            end_addr <= end_aligned;
          end
        end
        FETCH: begin
          if (mem_gnt_i) begin
            word_reg <= mem_data_i;
            char_idx <= 4'd0;
          end
        end
        LOAD: begin
          shifter  <= {1'b1, char_code, 1'b0};
          word_reg <= {word_reg[27:0], 4'h0};
          baud_cnt <= 16'd0;
          bit_cnt  <= 4'd0;
        end
        SHIFT: begin
          if (bit_end) begin
            baud_cnt <= 16'd0;
            shifter  <= {1'b1, shifter[9:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9 && char_idx != 4'd8) begin
              char_idx <= char_idx + 4'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        NEXT: begin
          cur_addr <= cur_inc[31:0];
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_dump_uart.sv
// tb_sig_dump_uart: directed bench for sig_dump_uart with a grant-delay
// memory responder and a mid-bit sampling UART receiver.
`timescale 1ns/1ps

module tb_sig_dump_uart;

  localparam int BAUD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] begin_addr_i = 32'h0;
  logic [31:0] end_addr_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0;
  logic        tx_pin_o;
  logic        busy_o;
  logic        done_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int accept_cyc = 0;

  bit          rand_mode = 1'b1;
  bit          spurious = 1'b0;
  int          grant_delay[$];
  int          req_idx = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  int          req_cycles = 0;
  int          addr_unstable = 0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] addr_log[$];

  logic [7:0]  rx[$];
  logic [7:0]  rx_byte;
  int          frame_err = 0;
  int          tx_low = 0;
  int          done_count = 0;
  int          done_cyc = 0;

  sig_dump_uart #(.BAUD_DIV(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .begin_addr_i (begin_addr_i),
    .end_addr_i   (end_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_data_i   (mem_data_i),
    .tx_pin_o     (tx_pin_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEADBEEF;
      32'h0000_0000: return 32'h00000001;
      32'h0000_0004: return 32'h0123ABCD;
      32'h0000_0008: return 32'hFFFFFFFF;
      32'hFFFF_FFF8: return 32'hCAFE0042;
      default:       return 32'h5A5A5A5A;
    endcase
  endfunction

  // Memory responder: grants each request after its programmed number of stall cycles
  always @(negedge clk) begin
    if (rand_mode) begin
      mem_gnt_i  = 1'($urandom);
      mem_data_i = $urandom;
    end else if (mem_req_o === 1'b1) begin
      req_cycles++;
      if (wait_cnt == 0) held_addr = mem_addr_o;
      else if (mem_addr_o !== held_addr) addr_unstable++;
      cur_delay = (req_idx < grant_delay.size()) ? grant_delay[req_idx] : 0;
      if (wait_cnt >= cur_delay) begin
        mem_gnt_i  = 1'b1;
        mem_data_i = memRead(mem_addr_o);
        addr_log.push_back(mem_addr_o);
        req_idx++;
        wait_cnt = 0;
      end else begin
        mem_gnt_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_gnt_i  = spurious;
      mem_data_i = 32'h0BAD_0BAD;
      wait_cnt   = 0;
    end
  end

  // Line, done and low-level monitors
  always @(negedge clk) begin
    if (tx_pin_o === 1'b0) tx_low++;
    if (done_o === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  // UART receiver sampling near the middle of each bit cell
  initial begin
    forever begin
      @(negedge clk);
      if (tx_pin_o === 1'b0) begin
        @(negedge clk);
        if (tx_pin_o !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          rx_byte[i] = tx_pin_o;
        end
        repeat (BAUD) @(negedge clk);
        if (tx_pin_o !== 1'b1) frame_err++;
        rx.push_back(rx_byte);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] b, input logic [31:0] e);
    @(negedge clk);
    begin_addr_i = b;
    end_addr_i   = e;
    start_i      = 1'b1;
    @(negedge clk);
    start_i      = 1'b0;
    begin_addr_i = $urandom;
    end_addr_i   = $urandom;
    accept_cyc   = cyc;
  endtask

  task automatic waitDone(input int prev, input int budget);
    for (int i = 0; i < budget && done_count == prev; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clearLogs();
    rx.delete();
    addr_log.delete();
    grant_delay.delete();
    req_idx   = 0;
    frame_err = 0;
  endtask

  task automatic checkRx(input string tag, input string exp);
    checkOutput({tag, "_len"}, 32'(rx.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++) begin
      if (i < rx.size()) checkOutput(tag, 32'(rx[i]), 32'(exp[i]));
    end
    checkOutput({tag, "_framing"}, 32'(frame_err), 32'd0);
  endtask

  logic [31:0] empty_begin[3] = '{32'h0000_0020, 32'h0000_0030, 32'hFFFF_FFFE};
  logic [31:0] empty_end[3]   = '{32'h0000_0020, 32'h0000_0010, 32'h0000_0003};

  // Directed sequence of scenarios
  initial begin
    int d;
    int tl;
    int rc;

    // Reset held with random inputs
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_i      = 1'($urandom);
      begin_addr_i = $urandom;
      end_addr_i   = $urandom;
    end
    @(negedge clk);
    checkOutput("rst_tx", 32'(tx_pin_o), 32'd1);
    checkOutput("rst_req", 32'(mem_req_o), 32'd0);
    checkOutput("rst_addr", mem_addr_o, 32'h0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    rand_mode = 1'b0;
    start_i   = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single word with immediate grant
    clearLogs();
    grant_delay = '{0};
    d = done_count;
    applyStimulus(32'h100, 32'h104);
    checkOutput("sw_busy", 32'(busy_o), 32'd1);
    checkOutput("sw_req", 32'(mem_req_o), 32'd1);
    checkOutput("sw_addr", mem_addr_o, 32'h100);
    waitUntil(accept_cyc + 1);
    checkOutput("sw_load_idle_line", 32'(tx_pin_o), 32'd1);
    waitUntil(accept_cyc + 2);
    checkOutput("sw_start_bit", 32'(tx_pin_o), 32'd0);
    waitDone(d, 2000);
    checkOutput("sw_done_once", 32'(done_count), 32'(d + 1));
    checkOutput("sw_cycles", 32'(done_cyc - accept_cyc), 32'd371);
    checkOutput("sw_busy_after", 32'(busy_o), 32'd0);
    checkOutput("sw_nreq", 32'(addr_log.size()), 32'd1);
    if (addr_log.size() > 0) checkOutput("sw_req_addr", addr_log[0], 32'h100);
    checkRx("sw_rx", "deadbeef\n");

    // Three words with grant stalls, spurious grants and an ignored start
    clearLogs();
    grant_delay = '{0, 3, 7};
    spurious    = 1'b1;
    rc          = req_cycles;
    addr_unstable = 0;
    d = done_count;
    applyStimulus(32'h0, 32'hC);
    repeat (10) @(negedge clk);
    start_i      = 1'b1;
    begin_addr_i = 32'h100;
    end_addr_i   = 32'h200;
    @(negedge clk);
    start_i = 1'b0;
    waitDone(d, 5000);
    spurious = 1'b0;
    checkOutput("mw_done_once", 32'(done_count), 32'(d + 1));
    checkOutput("mw_cycles", 32'(done_cyc - accept_cyc), 32'd1123);
    checkOutput("mw_req_cycles", 32'(req_cycles - rc), 32'd13);
    checkOutput("mw_addr_stable", 32'(addr_unstable), 32'd0);
    checkOutput("mw_nreq", 32'(addr_log.size()), 32'd3);
    if (addr_log.size() == 3) begin
      checkOutput("mw_addr0", addr_log[0], 32'h0);
      checkOutput("mw_addr1", addr_log[1], 32'h4);
      checkOutput("mw_addr2", addr_log[2], 32'h8);
    end
    checkRx("mw_rx", "00000001\n0123abcd\nffffffff\n");

    // Empty, inverted and unaligned-empty ranges
    for (int k = 0; k < 3; k++) begin
      clearLogs();
      d  = done_count;
      tl = tx_low;
      rc = req_cycles;
      applyStimulus(empty_begin[k], empty_end[k]);
      checkOutput("empty_done_pulse", 32'(done_o), 32'd1);
      @(negedge clk);
      checkOutput("empty_done_low", 32'(done_o), 32'd0);
      checkOutput("empty_busy_low", 32'(busy_o), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("empty_done_once", 32'(done_count), 32'(d + 1));
      checkOutput("empty_no_req", 32'(req_cycles), 32'(rc));
      checkOutput("empty_line_high", 32'(tx_low), 32'(tl));
    end

    // Range ending at the top of the address space
    clearLogs();
    d = done_count;
    applyStimulus(32'hFFFF_FFF8, 32'hFFFF_FFFF);
    waitDone(d, 2000);
    checkOutput("wrap_done_once", 32'(done_count), 32'(d + 1));
    checkOutput("wrap_cycles", 32'(done_cyc - accept_cyc), 32'd371);
    checkOutput("wrap_nreq", 32'(addr_log.size()), 32'd1);
    if (addr_log.size() > 0) checkOutput("wrap_addr", addr_log[0], 32'hFFFF_FFF8);
    checkRx("wrap_rx", "cafe0042\n");

    // Reset during the third data bit of the first character
    clearLogs();
    d = done_count;
    applyStimulus(32'h0, 32'h8);
    waitUntil(accept_cyc + 15);
    checkOutput("mid_bit2_low", 32'(tx_pin_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_tx", 32'(tx_pin_o), 32'd1);
    checkOutput("mid_rst_req", 32'(mem_req_o), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("mid_no_done", 32'(done_count), 32'(d));

    // Clean dump after the aborted one
    clearLogs();
    grant_delay = '{0};
    d = done_count;
    applyStimulus(32'h100, 32'h104);
    waitDone(d, 2000);
    checkOutput("post_done_once", 32'(done_count), 32'(d + 1));
    checkOutput("post_nreq", 32'(addr_log.size()), 32'd1);
    checkRx("post_rx", "deadbeef\n");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
